// File: rtl/mdarr_lane_serializer.sv
// Serializes one [0:D0-1][1:D1][1:D2] packed word into D0*D1 lane beats, innermost row per beat.
// A new word may be taken on the last-beat handshake, so back-to-back words stream with no bubble.
module mdarr_lane_serializer #(
  parameter int D0    = 5,
  parameter int D1    = 3,
  parameter int D2    = 3,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [0:D0-1][1:D1][1:D2]     in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:D2]                   out_lane,
  output logic [$clog2(D0)-1:0]         out_i0,
  output logic [$clog2(D1+1)-1:0]       out_i1,
  output logic                          out_first,
  output logic                          out_last,
  output logic                          xz_seen,
  output logic [CNT_W-1:0]              words_sent
);

  localparam int I0_W = $clog2(D0);
  localparam int I1_W = $clog2(D1+1);
  localparam logic [I0_W-1:0] I0_LAST  = I0_W'(D0-1);
  localparam logic [I1_W-1:0] I1_FIRST = I1_W'(1);
  localparam logic [I1_W-1:0] I1_LAST  = I1_W'(D1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                      state;
  logic [0:D0-1][1:D1][1:D2]   hold;
  logic [I0_W-1:0]             i0;
  logic [I1_W-1:0]             i1;
  logic                        at_first, at_last, beat_go, take, xz_in;

  assign at_first = (i0 == '0) && (i1 == I1_FIRST);
  assign at_last  = (i0 == I0_LAST) && (i1 == I1_LAST);
  assign beat_go  = (state == SEND) && out_ready;

  // Ready opens on the last-beat handshake so the next word overlaps the final beat.
  assign in_ready = !rst && ((state == IDLE) || (beat_go && at_last));
  assign take     = in_valid && in_ready;

  // Reduction XOR collapses to x if any bit is x/z; only meaningful in a 4-state simulator.
  assign xz_in    = (^in_data === 1'bx);

  // Lane is muxed from the holding register only, never straight from in_data.
  assign out_lane  = hold[i0][i1];
  assign out_i0    = i0;
  assign out_i1    = i1;
  assign out_first = out_valid && at_first;
  assign out_last  = out_valid && at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      hold       <= '0;
      i0         <= '0;
      i1         <= I1_FIRST;
      xz_seen    <= 1'b0;
      words_sent <= '0;
    end else begin
      xz_seen <= 1'b0;
      unique case (state)
        IDLE: ;
        SEND: begin
          if (out_ready) begin
            if (at_last) begin
              words_sent <= words_sent + CNT_W'(1);
              state      <= IDLE;
              out_valid  <= 1'b0;
              i0         <= '0;
              i1         <= I1_FIRST;
            end else if (i1 == I1_LAST) begin
              i1 <= I1_FIRST;
              i0 <= i0 + I0_W'(1);
            end else begin
              i1 <= i1 + I1_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Capture overrides the end-of-word return to IDLE above.
      if (take) begin
        hold      <= in_data;
        i0        <= '0;
        i1        <= I1_FIRST;
        state     <= SEND;
        out_valid <= 1'b1;
        xz_seen   <= xz_in;
      end
    end
  end

endmodule

// File: tb/tb_mdarr_lane_serializer.sv
// Scoreboard bench: each driven word pushes its expected beats; the monitor pops them on handshakes.
module tb_mdarr_lane_serializer;
  localparam int D0 = 5, D1 = 3, D2 = 3;
  localparam int NB = D0*D1*D2;

  typedef logic [0:D0-1][1:D1][1:D2] word_t;
  typedef struct {
    logic [2:0] lane;
    logic [2:0] i0;
    logic [1:0] i1;
    logic       first, last, xz;
  } beat_t;

  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  word_t       in_data = '0;
  logic        in_ready, out_valid, out_first, out_last, xz_seen;
  logic [1:D2] out_lane;
  logic [2:0]  out_i0;
  logic [1:0]  out_i1;
  logic [15:0] words_sent;
  logic        in_ready2, out_valid2, out_first2, out_last2, xz_seen2;
  logic [1:D2] out_lane2;
  logic [2:0]  out_i02;
  logic [1:0]  out_i12;
  logic [1:0]  words_sent2;

  mdarr_lane_serializer #(.D0(D0), .D1(D1), .D2(D2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane), .out_i0(out_i0),
    .out_i1(out_i1), .out_first(out_first), .out_last(out_last), .xz_seen(xz_seen),
    .words_sent(words_sent));

  mdarr_lane_serializer #(.D0(D0), .D1(D1), .D2(D2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_lane(out_lane2), .out_i0(out_i02),
    .out_i1(out_i12), .out_first(out_first2), .out_last(out_last2), .xz_seen(xz_seen2),
    .words_sent(words_sent2));

  always #5 clk = ~clk;

  int          vecs = 0, errs = 0, beats = 0;
  int          exp_words = 0;
  beat_t       sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor state
  bit          newbeat = 1'b1, stall_prev = 1'b0, ws_pending = 1'b0, cap_prev = 1'b0;
  logic [12:0] prev_vec;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      newbeat = 1'b1; stall_prev = 1'b0; ws_pending = 1'b0; cap_prev = 1'b0;
      exp_words = 0;
    end else begin
      if (cap_prev) chk("latency", {30'd0, out_valid, out_first}, 32'd3);
      if (ws_pending) begin
        chk("words_sent", words_sent, exp_words[15:0]);
        chk("words_sent_w2", words_sent2, exp_words[1:0]);
      end
      ws_pending = 1'b0;
      if (stall_prev)
        chk("hold", {out_valid, out_lane, out_i0, out_i1, out_first, out_last, in_ready}, prev_vec);
      if (out_valid) chk("in_ready", in_ready, out_ready && out_last);
      if (out_valid && newbeat && out_first)
        chk("xz_seen", xz_seen, (sb.size() != 0) ? sb[0].xz : 1'b0);
      else if (xz_seen !== 1'b0)
        chk("xz_spurious", xz_seen, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = sb.pop_front();
          chk("lane", out_lane, e.lane);
          chk("idx", {out_i0, out_i1}, {e.i0, e.i1});
          chk("flags", {out_first, out_last}, {e.first, e.last});
          chk("dut2_beat", {out_valid2, out_lane2, out_i02, out_i12, out_first2, out_last2},
              {out_valid, out_lane, out_i0, out_i1, out_first, out_last});
          if (e.last) begin exp_words++; ws_pending = 1'b1; end
        end
        beats++;
        newbeat = 1'b1;
      end else begin
        newbeat = !out_valid;
      end
      stall_prev = out_valid && !out_ready;
      prev_vec   = {out_valid, out_lane, out_i0, out_i1, out_first, out_last, in_ready};
      cap_prev   = in_valid && in_ready;
    end
  end

  task automatic send_word(input word_t w, input bit keep_valid);
    beat_t e;
    bit    xz;
    int    n = 0;
    xz = (^w === 1'bx);
    for (int a = 0; a < D0; a++)
      for (int b = 1; b <= D1; b++) begin
        e.lane  = w[a][b];
        e.i0    = 3'(a);
        e.i1    = 2'(b);
        e.first = (a == 0) && (b == 1);
        e.last  = (a == D0-1) && (b == D1);
        e.xz    = xz && e.first;
        sb.push_back(e);
      end
    in_data  = w;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready && !rst) begin @(posedge clk); break; end
      if (++n > 500) begin chk("capture_timeout", 0, 1); break; end
    end
    #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats < target) begin
      @(posedge clk); #1;
      if (++n > 500) begin chk("beat_timeout", 0, 1); break; end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while ((sb.size() != 0 || out_valid) && n < 500);
    if (n >= 500) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  function automatic word_t rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[NB-1:0];
  endfunction

  function automatic word_t ramp_word();
    word_t w;
    for (int a = 0; a < D0; a++)
      for (int b = 1; b <= D1; b++) w[a][b] = 3'(a*3 + b);
    return w;
  endfunction

  initial begin
    word_t w;
    int    base;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outs", {out_valid, out_lane, out_i0, out_i1, out_first, out_last, xz_seen},
        {1'b0, 3'b000, 3'd0, 2'd1, 1'b0, 1'b0, 1'b0});
    chk("rst_words", words_sent, 0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("post_rst_ready", in_ready, 1);

    // Single ramp word: lanes 1..15 mod 8
    base = beats;
    send_word(ramp_word(), 1'b0);
    wait_idle();
    chk("t1_beats", beats - base, 15);
    chk("t1_words", words_sent, 1);

    // Backpressure at beat 7
    base = beats;
    send_word(rand_word(), 1'b0);
    wait_beats(base + 6);
    out_ready = 1'b0;
    chk("bp_i0", out_i0, 2);
    chk("bp_i1", out_i1, 1);
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    chk("t2_beats", beats - base, 15);

    // Back-to-back words with in_valid held
    base = beats;
    send_word(rand_word(), 1'b1);
    send_word(ramp_word() ^ rand_word(), 1'b0);
    wait_idle();
    chk("t3_beats", beats - base, 30);
    chk("t3_words", words_sent, 4);

    // x/z content in lane [2][3]
    w = rand_word();
    w[2][3] = 3'b1x0;
    send_word(w, 1'b0);
    wait_idle();

    // Reset mid-word at beat 6
    base = beats;
    send_word(ramp_word(), 1'b0);
    wait_beats(base + 5);
    rst = 1'b1;
    #1 chk("mid_rst_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_words", words_sent, 0);
    chk("mid_rst_ready_after", in_ready, 1);
    send_word(rand_word(), 1'b0);
    wait_idle();

    // Counter wrap on the CNT_W=2 instance: 1,2,3,0,1
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_word(rand_word(), 1'b0);
      wait_idle();
    end
    chk("wrap_final", words_sent2, 1);
    chk("wrap_wide", words_sent, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
    $fatal(1);
  end

endmodule
